debounce_filter: RTL and testbench

// Conditions a raw asynchronous level (button, strap, external GPIO) before it

---
 rtl/debounce_filter.sv | 112 +++++++++++
 tb/tb_debounce_filter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_filter.sv
// Input conditioner for a raw asynchronous level. The level is synchronised into
// clk_i, and a change is accepted only after it has held for threshold_i cycles.
module debounce_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic               signal_i,
    input  logic [COUNT_W-1:0] threshold_i,
    output logic               signal_o,
    output logic               rise_o,
    output logic               fall_o,
    output logic               busy_o
);

    typedef enum logic {
        STABLE,
        QUALIFY
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;

    state_t                 state_q, state_d;
    logic [COUNT_W-1:0]     cnt_q, cnt_d;
    logic [COUNT_W-1:0]     thr_m1;
    logic                   commit;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // its inputs from before the clock edge, independent of statement order.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];

    // A zero threshold behaves as one, so thr_eff-1 is zero in both cases.
    assign thr_m1 = (threshold_i == '0) ? '0 : threshold_i - COUNT_W'(1);

    // NOTE: every signal driven here gets a default first; otherwise a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;

        unique case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s_sync != level_q) begin
                    if (thr_m1 == '0) begin
                        commit = 1'b1;
                    end else begin
                        cnt_d   = COUNT_W'(1);
                        state_d = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (s_sync == level_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (cnt_q >= thr_m1) begin
                    commit = 1'b1;
                end else begin
                    cnt_d = cnt_q + COUNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = STABLE;
            end
        endcase

        if (commit) begin
            cnt_d   = '0;
            state_d = STABLE;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                level_q <= s_sync;
            end
            rise_q <= commit & s_sync;
            fall_q <= commit & ~s_sync;
        end
    end

    assign signal_o = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign busy_o   = (state_q == QUALIFY);

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter: a run-length reference model is checked
// every cycle, alongside hand-computed latencies and pulse counts.
module tb_debounce_filter;

    localparam int S = 2;
    localparam int W = 16;

    logic         clk_i       = 1'b0;
    logic         arst_ni     = 1'b1;
    logic         signal_i    = 1'b0;
    logic [W-1:0] threshold_i = W'(4);
    logic         signal_o;
    logic         rise_o;
    logic         fall_o;
    logic         busy_o;

    debounce_filter #(.SYNC_STAGES(S), .COUNT_W(W)) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .signal_i    (signal_i),
        .threshold_i (threshold_i),
        .signal_o    (signal_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rise  = 0;
    int n_fall  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: the synchronised level is the input sampled S edges ago; the
    // output follows it once it has disagreed for thr_eff consecutive edges.
    bit m_hist[S];
    bit m_sig, m_rise, m_fall, m_busy;
    int m_run;

    initial begin
        forever begin
            @(posedge clk_i or negedge arst_ni);
            if (!arst_ni) begin
                foreach (m_hist[i]) m_hist[i] = 1'b0;
                m_sig = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_run = 0;
            end else begin
                bit s;
                int thr;
                s   = m_hist[S-1];
                for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = signal_i;
                thr = (threshold_i == 0) ? 1 : int'(threshold_i);
                m_rise = 0;
                m_fall = 0;
                if (s != m_sig) begin
                    m_run++;
                    if (m_run >= thr) begin
                        m_sig  = s;
                        m_rise = s;
                        m_fall = !s;
                        m_run  = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_busy = (m_run != 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            check("model_signal", signal_o, m_sig);
            check("model_rise",   rise_o,   m_rise);
            check("model_fall",   fall_o,   m_fall);
            check("model_busy",   busy_o,   m_busy);
            check("rise_fall_excl", rise_o & fall_o, 0);
            n_rise += int'(rise_o);
            n_fall += int'(fall_o);
        end
    end

    initial begin
        int base_r, base_f, lat;
        bit busy_seen;

        // 1: reset with input high, threshold 4 -> rise at edge 6 after release
        #1 arst_ni = 1'b0;
        signal_i    = 1'b1;
        threshold_i = W'(4);
        repeat (3) tick();
        check("t1_reset_signal", signal_o, 0);
        check("t1_reset_busy",   busy_o,   0);
        arst_ni = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("t1_signal", signal_o, (e >= 6) ? 1 : 0);
            check("t1_rise",   rise_o,   (e == 6) ? 1 : 0);
        end

        // 2: 5-cycle low glitch with threshold 8 is discarded
        repeat (3) tick();
        threshold_i = W'(8);
        base_r = n_rise; base_f = n_fall;
        busy_seen = 0;
        signal_i = 1'b0;
        repeat (5) begin tick(); busy_seen |= busy_o; end
        signal_i = 1'b1;
        repeat (15) begin tick(); busy_seen |= busy_o; end
        check("t2_busy_seen", busy_seen, 1);
        check("t2_busy_end",  busy_o,    0);
        check("t2_signal",    signal_o,  1);
        check("t2_rises",     n_rise - base_r, 0);
        check("t2_falls",     n_fall - base_f, 0);

        // 3: bounce train then hold high, threshold 10 -> one rise 12 edges later
        threshold_i = W'(10);
        signal_i = 1'b0;
        repeat (20) tick();
        check("t3_pre_signal", signal_o, 0);
        base_r = n_rise; base_f = n_fall;
        for (int i = 0; i < 10; i++) begin
            signal_i = (i % 2 == 0);
            repeat (3) tick();
        end
        signal_i = 1'b1;
        lat = -1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (rise_o && lat < 0) lat = t;
        end
        check("t3_latency", lat, 12);
        check("t3_rises",   n_rise - base_r, 1);
        check("t3_falls",   n_fall - base_f, 0);

        // 4: threshold 0 acts as 1 -> each change visible at edge 3
        threshold_i = '0;
        signal_i = 1'b0;
        repeat (10) tick();
        base_r = n_rise; base_f = n_fall;
        signal_i = 1'b1;
        lat = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (rise_o && lat < 0) lat = t;
        end
        check("t4_rise_latency", lat, 3);
        signal_i = 1'b0;
        lat = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (fall_o && lat < 0) lat = t;
        end
        check("t4_fall_latency", lat, 3);
        check("t4_rises", n_rise - base_r, 1);
        check("t4_falls", n_fall - base_f, 1);

        // 5: async reset while qualifying with cnt=5, then full requalification
        threshold_i = W'(10);
        signal_i = 1'b1;
        repeat (7) tick();
        check("t5_busy_before", busy_o, 1);
        arst_ni = 1'b0;
        #1;
        check("t5_async_signal", signal_o, 0);
        check("t5_async_rise",   rise_o,   0);
        check("t5_async_fall",   fall_o,   0);
        check("t5_async_busy",   busy_o,   0);
        repeat (2) tick();
        arst_ni = 1'b1;
        lat = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (rise_o && lat < 0) lat = t;
        end
        check("t5_requal_latency", lat, 12);

        // 6: square wave, half-period 100, threshold 4 -> every edge 6 cycles late
        threshold_i = W'(4);
        repeat (5) tick();
        base_r = n_rise; base_f = n_fall;
        for (int h = 0; h < 20; h++) begin
            signal_i = (h % 2 == 1);
            lat = -1;
            for (int t = 1; t <= 100; t++) begin
                tick();
                if ((rise_o || fall_o) && lat < 0) lat = t;
            end
            check("t6_latency", lat, 6);
        end
        check("t6_rises", n_rise - base_r, 10);
        check("t6_falls", n_fall - base_f, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
